dictionary_encoder: RTL and testbench
=====================================

DICTIONARY_ENCODER -- requirements
Module: dictionary_encoder

Interface
REQ-001 SHALL have parameter VALUE_BITS, default 32, meaning width of one dictionary value.
REQ-002 SHALL have parameter DEPTH, default 64, meaning number of dictionary entries (power of two, 2..256); ID_BITS = clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports in_values_data/valid/ready/last  in/in/out/in  VALUE_BITS/1/1/1  build-phase value stream.
REQ-006 SHALL have ports in_lookup_data/valid/ready/last  in/in/out/in  VALUE_BITS/1/1/1  lookup-phase value stream.
REQ-007 SHALL have ports out_id/out_hit/out_valid/out_ready/out_last  out/out/out/in/out  ID_BITS/1/1/1/1  encoded id stream.
REQ-008 SHALL have port entry_count  output  ID_BITS+1  number of occupied entries.
REQ-009 SHALL have port overflow  output  1  sticky flag, a distinct build value was dropped because the table was full.

Function
REQ-010 SHALL implement FSM states BUILD and LOOKUP; reset state BUILD.
REQ-011 SHALL, in BUILD, drive in_values_ready=1 and in_lookup_ready=0; in LOOKUP, drive in_values_ready=0.
REQ-012 SHALL compare each accepted build value against all occupied entries in the acceptance cycle; the compare includes an entry written in the immediately preceding cycle.
REQ-013 SHALL, for a build value with no match and entry_count<DEPTH, write it to entry index entry_count and increment entry_count at the next edge.
REQ-014 SHALL, for a distinct build value with entry_count==DEPTH, drop the value, set overflow, and leave the table unchanged.
REQ-015 SHALL transition BUILD->LOOKUP on the edge after accepting a build beat with last=1, including a beat that was itself dropped or deduplicated.
REQ-016 SHALL, in LOOKUP, process lookups through a 2-stage pipeline (stage 1: registered per-entry match vector; stage 2: lowest-index priority encode into output register); latency from in_lookup handshake to out_valid is 2 cycles.
REQ-017 SHALL drive out_hit=1 with out_id=lowest matching index on a match, and out_hit=0 with out_id=0 on a miss.
REQ-018 SHALL stall all pipeline stages while out_valid=1 and out_ready=0, hold out_* stable, and drive in_lookup_ready=1 only when stage 1 is empty or advancing; sustained throughput 1 lookup/cycle.
REQ-019 SHALL carry in_lookup_last through the pipeline unchanged to out_last.
REQ-020 SHALL stop accepting lookups after a last beat until that beat handshakes on out; on that handshake, clear all entries, entry_count and overflow, and return to BUILD.
REQ-021 SHALL, on an empty lookup stream, not enter BUILD until a last beat is presented; a build stream with zero entries followed by lookups returns out_hit=0 for every lookup.
REQ-022 SHALL never let out_valid fall without a handshake.

Reset
REQ-023 SHALL, while rst=1 at an edge, return to BUILD, empty the pipeline, invalidate all entries, and drive out_valid=0, out_id=0, out_hit=0, out_last=0, entry_count=0, overflow=0, in_lookup_ready=0 on the next cycle.
REQ-024 SHALL discard any in-flight lookup or partial build on reset mid-operation; entry data need not be cleared, only valid bits.

Configuration
REQ-025 SHALL support macro DICT_ENCODER_DEDUP_EN: when defined, deduplication per REQ-012/013 applies; when undefined, every accepted build value allocates a new entry (duplicates occupy separate indices) and lookup returns the lowest matching index per REQ-017.

Verification
REQ-026 SHALL cover: build 0xA,0xB,0xC(last); lookup 0xB,0xD,0xA(last) -> (id1,hit),(id0,miss),(id0,hit), out_last on third beat, then state BUILD with entry_count=0.
REQ-027 SHALL cover: DEDUP_EN defined, build 0x5,0x5,0x7(last) -> entry_count=2, lookup 0x7 -> id1; undefined -> entry_count=3, lookup 0x5 -> id0, lookup 0x7 -> id2.
REQ-028 SHALL cover: DEPTH=4, build 5 distinct values -> entry_count=4, overflow=1, fifth value lookup -> miss.
REQ-029 SHALL cover: 16 back-to-back lookups with out_ready toggled randomly -> order preserved, each out beat held stable until handshake, no loss.
REQ-030 SHALL cover: rst=1 asserted one cycle mid-lookup with 2 beats in flight -> next cycle out_valid=0, entry_count=0, state BUILD; a subsequent build/lookup behaves as after power-up.

Source files
------------

// File: rtl/dictionary_encoder.sv
`default_nettype none
// ============================================================================
// Module   : dictionary_encoder
// Summary  : Builds a value dictionary from one stream. It then maps a lookup
//            stream to entry ids through a 2-stage match / priority pipeline.
//            Optional macro DICT_ENCODER_DEDUP_EN: skip duplicate build values.
// Revision : 1.0 - initial release
// ============================================================================
module dictionary_encoder #(
    parameter int VALUE_BITS = 32,
    parameter int DEPTH      = 64,
    localparam int ID_BITS   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_BITS-1:0] in_values_data,
    input  logic                  in_values_valid,
    output logic                  in_values_ready,
    input  logic                  in_values_last,
    input  logic [VALUE_BITS-1:0] in_lookup_data,
    input  logic                  in_lookup_valid,
    output logic                  in_lookup_ready,
    input  logic                  in_lookup_last,
    output logic [ID_BITS-1:0]    out_id,
    output logic                  out_hit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [ID_BITS:0]      entry_count,
    output logic                  overflow
);

    localparam logic [0:0]       c_ST_BUILD  = 1'b0;
    localparam logic [0:0]       c_ST_LOOKUP = 1'b1;
    localparam logic [ID_BITS:0] c_FULL      = (ID_BITS+1)'(DEPTH);

    logic [0:0]            state_q, state_d;
    logic [VALUE_BITS-1:0] entry_data_q [DEPTH];
    logic [DEPTH-1:0]      entry_valid_q, entry_valid_d;
    logic [ID_BITS:0]      entry_count_q, entry_count_d;
    logic                  overflow_q, overflow_d;
    logic                  last_seen_q, last_seen_d;

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_last_q, s1_last_d;
    logic [DEPTH-1:0]      s1_match_q, s1_match_d;

    logic                  out_valid_q, out_valid_d;
    logic                  out_hit_q, out_hit_d;
    logic                  out_last_q, out_last_d;
    logic [ID_BITS-1:0]    out_id_q, out_id_d;

    logic                  w_build_fire, w_is_new, w_full, w_alloc, w_drop;
    logic                  w_lookup_fire, w_stall, w_out_fire, w_done;
    logic [DEPTH-1:0]      w_lookup_match;
    logic                  w_prio_hit;
    logic [ID_BITS-1:0]    w_prio_id;

    // Entries are compared straight from registers, so a value written on the
    // previous edge is already visible to the next build beat.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lookup_match
            assign w_lookup_match[gi] = entry_valid_q[gi] && (entry_data_q[gi] == in_lookup_data);
        end
    endgenerate

`ifdef DICT_ENCODER_DEDUP_EN
    logic [DEPTH-1:0] w_build_match;
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_build_match
            assign w_build_match[gi] = entry_valid_q[gi] && (entry_data_q[gi] == in_values_data);
        end
    endgenerate
    assign w_is_new = ~|w_build_match;
`else
    assign w_is_new = 1'b1;
`endif

    assign w_build_fire  = in_values_valid && in_values_ready;
    assign w_full        = (entry_count_q == c_FULL);
    assign w_alloc       = w_build_fire && w_is_new && !w_full;
    assign w_drop        = w_build_fire && w_is_new && w_full;
    assign w_lookup_fire = in_lookup_valid && in_lookup_ready;
    assign w_stall       = out_valid_q && !out_ready;
    assign w_out_fire    = out_valid_q && out_ready;
    assign w_done        = w_out_fire && out_last_q;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_BUILD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_BUILD:  if (w_build_fire && in_values_last) state_d = c_ST_LOOKUP;
            c_ST_LOOKUP: if (w_done) state_d = c_ST_BUILD;
            default:     state_d = c_ST_BUILD;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_values_ready = (state_q == c_ST_BUILD);
        in_lookup_ready = (state_q == c_ST_LOOKUP) && !last_seen_q && (!s1_valid_q || !w_stall);
    end

    always_comb begin
        entry_valid_d = entry_valid_q;
        entry_count_d = entry_count_q;
        overflow_d    = overflow_q;
        last_seen_d   = last_seen_q;
        if (w_alloc) begin
            entry_valid_d[entry_count_q[ID_BITS-1:0]] = 1'b1;
            entry_count_d = entry_count_q + 1'b1;
        end
        if (w_drop) begin
            overflow_d = 1'b1;
        end
        if (w_lookup_fire && in_lookup_last) begin
            last_seen_d = 1'b1;
        end
        if (w_done) begin
            entry_valid_d = '0;
            entry_count_d = '0;
            overflow_d    = 1'b0;
            last_seen_d   = 1'b0;
        end
    end

    always_comb begin
        w_prio_hit = 1'b0;
        w_prio_id  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (s1_match_q[i]) begin
                w_prio_hit = 1'b1;
                w_prio_id  = ID_BITS'(i);
            end
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_match_d  = s1_match_q;
        out_valid_d = out_valid_q;
        out_hit_d   = out_hit_q;
        out_last_d  = out_last_q;
        out_id_d    = out_id_q;
        if (!w_stall) begin
            out_valid_d = s1_valid_q;
            out_hit_d   = s1_valid_q && w_prio_hit;
            out_id_d    = s1_valid_q ? w_prio_id : '0;
            out_last_d  = s1_valid_q && s1_last_q;
        end
        if (!s1_valid_q || !w_stall) begin
            s1_valid_d = w_lookup_fire;
            s1_match_d = w_lookup_match;
            s1_last_d  = w_lookup_fire && in_lookup_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_valid_q <= '0;
            entry_count_q <= '0;
            overflow_q    <= 1'b0;
            last_seen_q   <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_match_q    <= '0;
            out_valid_q   <= 1'b0;
            out_hit_q     <= 1'b0;
            out_last_q    <= 1'b0;
            out_id_q      <= '0;
        end else begin
            entry_valid_q <= entry_valid_d;
            entry_count_q <= entry_count_d;
            overflow_q    <= overflow_d;
            last_seen_q   <= last_seen_d;
            s1_valid_q    <= s1_valid_d;
            s1_last_q     <= s1_last_d;
            s1_match_q    <= s1_match_d;
            out_valid_q   <= out_valid_d;
            out_hit_q     <= out_hit_d;
            out_last_q    <= out_last_d;
            out_id_q      <= out_id_d;
        end
    end

    // Entry payload needs no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            entry_data_q[entry_count_q[ID_BITS-1:0]] <= in_values_data;
        end
    end

    assign out_id      = out_id_q;
    assign out_hit     = out_hit_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign entry_count = entry_count_q;
    assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_dictionary_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dictionary_encoder
// Summary  : Directed, table-driven bench for dictionary_encoder (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dictionary_encoder;

    localparam int VB    = 16;
    localparam int DEPTH = 4;
    localparam int IDB   = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [VB-1:0]  in_values_data;
    logic           in_values_valid, in_values_ready, in_values_last;
    logic [VB-1:0]  in_lookup_data;
    logic           in_lookup_valid, in_lookup_ready, in_lookup_last;
    logic [IDB-1:0] out_id;
    logic           out_hit, out_valid, out_ready, out_last;
    logic [IDB:0]   entry_count;
    logic           overflow;

    always #5 clk = ~clk;

    dictionary_encoder #(.VALUE_BITS(VB), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_values_data(in_values_data), .in_values_valid(in_values_valid),
        .in_values_ready(in_values_ready), .in_values_last(in_values_last),
        .in_lookup_data(in_lookup_data), .in_lookup_valid(in_lookup_valid),
        .in_lookup_ready(in_lookup_ready), .in_lookup_last(in_lookup_last),
        .out_id(out_id), .out_hit(out_hit), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last),
        .entry_count(entry_count), .overflow(overflow)
    );

    typedef struct packed {
        logic [VB-1:0]  val;
        logic           hit;
        logic [IDB-1:0] id;
    } lk_vec_t;

    lk_vec_t        vec29 [16];
    lk_vec_t        lk_tab [16];
    int             lk_n;
    logic [IDB-1:0] got_id [16];
    logic           got_hit [16];
    logic           got_last [16];
    int             got_n;
    int             errors = 0;
    int             checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_build(input logic [VB-1:0] v, input logic last);
        int t;
        t = 0;
        in_values_data  = v;
        in_values_valid = 1'b1;
        in_values_last  = last;
        while (!in_values_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("build_ready", in_values_ready, 1);
        @(posedge clk); #1;
        in_values_valid = 1'b0;
        in_values_last  = 1'b0;
    endtask

    task automatic add_lk(input logic [VB-1:0] v, input logic hit, input logic [IDB-1:0] id);
        lk_tab[lk_n] = '{val: v, hit: hit, id: id};
        lk_n++;
    endtask

    task automatic run_lookups(input bit rand_ready);
        int             sent;
        bit             pend, fire;
        logic [IDB-1:0] pid;
        logic           phit, plast;
        sent = 0; got_n = 0; pend = 0; pid = '0; phit = 0; plast = 0;
        for (int i = 0; i < 16; i++) begin
            got_id[i] = 'x; got_hit[i] = 1'bx; got_last[i] = 1'bx;
        end
        for (int cyc = 0; cyc < 500 && got_n < lk_n; cyc++) begin
            in_lookup_valid = (sent < lk_n);
            if (sent < lk_n) begin
                in_lookup_data = lk_tab[sent].val;
                in_lookup_last = (sent == lk_n - 1);
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (pend) begin
                check("held_valid", out_valid, 1);
                check("held_id", out_id, pid);
                check("held_hit", out_hit, phit);
                check("held_last", out_last, plast);
            end
            if (out_valid && out_ready) begin
                if (got_n < 16) begin
                    got_id[got_n] = out_id; got_hit[got_n] = out_hit; got_last[got_n] = out_last;
                end
                got_n++;
                pend = 0;
            end else if (out_valid) begin
                pend = 1; pid = out_id; phit = out_hit; plast = out_last;
            end
            fire = in_lookup_valid && in_lookup_ready;
            @(posedge clk); #1;
            if (fire) sent++;
        end
        in_lookup_valid = 1'b0;
        in_lookup_last  = 1'b0;
        out_ready       = 1'b1;
        check("lookup_count", got_n, lk_n);
    endtask

    task automatic check_lookups(input string tag);
        for (int i = 0; i < lk_n; i++) begin
            check($sformatf("%s[%0d].hit", tag, i), got_hit[i], lk_tab[i].hit);
            check($sformatf("%s[%0d].id", tag, i), got_id[i], lk_tab[i].id);
            check($sformatf("%s[%0d].last", tag, i), got_last[i], (i == lk_n - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec29[0]  = '{16'h22, 1'b1, 2'd1};  vec29[1]  = '{16'h44, 1'b1, 2'd3};
        vec29[2]  = '{16'h55, 1'b0, 2'd0};  vec29[3]  = '{16'h11, 1'b1, 2'd0};
        vec29[4]  = '{16'h33, 1'b1, 2'd2};  vec29[5]  = '{16'h33, 1'b1, 2'd2};
        vec29[6]  = '{16'h00, 1'b0, 2'd0};  vec29[7]  = '{16'h44, 1'b1, 2'd3};
        vec29[8]  = '{16'h11, 1'b1, 2'd0};  vec29[9]  = '{16'h66, 1'b0, 2'd0};
        vec29[10] = '{16'h22, 1'b1, 2'd1};  vec29[11] = '{16'h33, 1'b1, 2'd2};
        vec29[12] = '{16'h44, 1'b1, 2'd3};  vec29[13] = '{16'h77, 1'b0, 2'd0};
        vec29[14] = '{16'h11, 1'b1, 2'd0};  vec29[15] = '{16'h22, 1'b1, 2'd1};

        rst = 1'b1;
        in_values_data = '0; in_values_valid = 1'b0; in_values_last = 1'b0;
        in_lookup_data = '0; in_lookup_valid = 1'b0; in_lookup_last = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_id", out_id, 0);
        check("rst_out_hit", out_hit, 0);
        check("rst_out_last", out_last, 0);
        check("rst_entry_count", entry_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_lookup_ready", in_lookup_ready, 0);
        check("rst_values_ready", in_values_ready, 1);

        // Basic build then lookup
        send_build(16'hA, 0); send_build(16'hB, 0); send_build(16'hC, 1);
        check("r026_count", entry_count, 3);
        check("r026_in_lookup_state", in_values_ready, 0);
        lk_n = 0;
        add_lk(16'hB, 1, 1); add_lk(16'hD, 0, 0); add_lk(16'hA, 1, 0);
        run_lookups(0);
        check_lookups("r026");
        check("r026_back_build", in_values_ready, 1);
        check("r026_count_clr", entry_count, 0);

        // Duplicate build values
        send_build(16'h5, 0); send_build(16'h5, 0); send_build(16'h7, 1);
        lk_n = 0;
`ifdef DICT_ENCODER_DEDUP_EN
        check("r027_count", entry_count, 2);
        add_lk(16'h7, 1, 1);
`else
        check("r027_count", entry_count, 3);
        add_lk(16'h5, 1, 0); add_lk(16'h7, 1, 2);
`endif
        run_lookups(0);
        check_lookups("r027");

        // Table overflow
        send_build(16'h1, 0); send_build(16'h2, 0); send_build(16'h3, 0);
        send_build(16'h4, 0); send_build(16'h5, 1);
        check("r028_count", entry_count, 4);
        check("r028_overflow", overflow, 1);
        lk_n = 0;
        add_lk(16'h4, 1, 3); add_lk(16'h5, 0, 0);
        run_lookups(0);
        check_lookups("r028");
        check("r028_overflow_clr", overflow, 0);

        // Back-to-back lookups under random backpressure, full table
        send_build(16'h11, 0); send_build(16'h22, 0); send_build(16'h33, 0); send_build(16'h44, 1);
        check("r029_count", entry_count, 4);
        check("r029_overflow", overflow, 0);
        lk_n = 0;
        for (int i = 0; i < 16; i++) add_lk(vec29[i].val, vec29[i].hit, vec29[i].id);
        run_lookups(1);
        check_lookups("r029");

        // Two-cycle lookup latency
        send_build(16'h77, 1);
        out_ready = 1'b1;
        in_lookup_data = 16'h77; in_lookup_valid = 1'b1; in_lookup_last = 1'b1;
        @(negedge clk);
        check("lat_ready", in_lookup_ready, 1);
        @(posedge clk); #1;
        in_lookup_valid = 1'b0; in_lookup_last = 1'b0;
        check("lat_c1_valid", out_valid, 0);
        check("lat_ready_after_last", in_lookup_ready, 0);
        @(posedge clk); #1;
        check("lat_c2_valid", out_valid, 1);
        check("lat_c2_hit", out_hit, 1);
        check("lat_c2_id", out_id, 0);
        check("lat_c2_last", out_last, 1);
        @(posedge clk); #1;
        check("lat_back_build", in_values_ready, 1);

        // Reset with two lookups in flight
        send_build(16'hA, 0); send_build(16'hB, 1);
        out_ready = 1'b0;
        in_lookup_data = 16'hA; in_lookup_valid = 1'b1; in_lookup_last = 1'b0;
        @(posedge clk); #1;
        in_lookup_data = 16'hB;
        @(posedge clk); #1;
        in_lookup_valid = 1'b0;
        check("r030_inflight_valid", out_valid, 1);
        check("r030_stall_ready", in_lookup_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        check("r030_out_valid", out_valid, 0);
        check("r030_count", entry_count, 0);
        check("r030_build", in_values_ready, 1);
        check("r030_lookup_ready", in_lookup_ready, 0);
        send_build(16'h9, 1);
        check("r030_new_count", entry_count, 1);
        lk_n = 0;
        add_lk(16'hB, 0, 0); add_lk(16'h9, 1, 0);
        run_lookups(0);
        check_lookups("r030");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
